mem_arbiter: RTL

- Two-port round-robin arbiter and sequencer for the 4x8 register-file memory.
- Accepts read and write requests from two requesters over a valid/ready handshake.
- Issues exactly one memory strobe per granted request.
- Returns read data to the requester that owns it with a one-cycle rvalid pulse.
- Sits between the requesters and the memory; the memory ports connect directly to the mem_* outputs and input.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a small register-file memory.
// One strobe per granted request; read data returns with a one-cycle rvalid pulse.
module mem_arbiter #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

   state_t            state;
   logic              prio;
   logic              cap_we;
   logic              any_valid;
   logic              win;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // prio only breaks ties; a lone requester always wins
   assign any_valid  = req0_valid | req1_valid;
   assign win        = (req0_valid & req1_valid) ? prio : req1_valid;
   assign req0_ready = reset & (state == IDLE) & any_valid & ~win;
   assign req1_ready = reset & (state == IDLE) & win;
   assign accept     = req0_ready | req1_ready;
   assign busy       = (state != IDLE);

   assign sel_we    = win ? req1_we    : req0_we;
   assign sel_addr  = win ? req1_addr  : req0_addr;
   assign sel_wdata = win ? req1_wdata : req0_wdata;

   // mem_addr/mem_wdata double as the capture registers, so they hold outside ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         prio        <= 1'b0;
         grant_id    <= 1'b0;
         cap_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         req0_rdata  <= '0;
         req1_rdata  <= '0;
      end else begin
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id  <= win;
                  cap_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_wr_en <= sel_we;
                  mem_rd_en <= ~sel_we;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cap_we) begin
                  prio  <= ~grant_id;
                  state <= IDLE;
               end else begin
                  state <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (grant_id) begin
                  req1_rdata  <= mem_rdata;
                  req1_rvalid <= 1'b1;
               end else begin
                  req0_rdata  <= mem_rdata;
                  req0_rvalid <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               prio  <= ~grant_id;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
